// File: rtl/ext_stage_pkg.sv
// ext_stage_pkg -- shared definitions for the extension stage.
//   ext_op_e      : 3-bit ExtOp mode codes (immediate and load-lane modes)
//   DATA_W_*      : legal datapath widths
//   IMM_W_MIN     : smallest legal immediate width
//   imm_w_max()   : largest legal immediate width for a given datapath width
//   params_legal(): combined legality test for a DATA_W/IMM_W pair
package ext_stage_pkg;

    typedef enum logic [2:0] {
        EXT_ZERO = 3'b000,
        EXT_SIGN = 3'b001,
        EXT_LUI  = 3'b010,
        EXT_BR   = 3'b011,
        EXT_LB   = 3'b100,
        EXT_LBU  = 3'b101,
        EXT_LH   = 3'b110,
        EXT_LHU  = 3'b111
    } ext_op_e;

    localparam int DATA_W_NARROW = 32;
    localparam int DATA_W_WIDE   = 64;
    localparam int IMM_W_MIN     = 8;

    function automatic int imm_w_max(input int data_w);
        return data_w / 2;
    endfunction

    function automatic bit params_legal(input int data_w, input int imm_w);
        return ((data_w == DATA_W_NARROW) || (data_w == DATA_W_WIDE)) &&
               (imm_w >= IMM_W_MIN) && (imm_w <= imm_w_max(data_w));
    endfunction

endpackage

// File: rtl/ext_core.sv
// ext_core -- purely combinational immediate / load-lane extender.
//   op       in  3       ExtOp mode code
//   data     in  DATA_W  immediate in low IMM_W bits, or a load word
//   off      in  OFF_W   byte offset used by the load modes
//   result   out DATA_W  extended value (0 for a misaligned halfword)
//   misalign out 1       halfword load with an odd byte offset
module ext_core
    import ext_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] data,
    input  logic [OFF_W-1:0]  off,
    output logic [DATA_W-1:0] result,
    output logic              misalign
);

    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] imm_sext;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;

    assign imm      = data[IMM_W-1:0];
    assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

    // Byte lane = off; halfword lane = off with its low bit dropped.
    assign byte_lane = data[{off, 3'b000} +: 8];
    assign half_lane = data[{off[OFF_W-1:1], 4'b0000} +: 16];

    always_comb begin
        result   = '0;
        misalign = 1'b0;
        case (op)
            EXT_ZERO: result = {{(DATA_W-IMM_W){1'b0}}, imm};
            EXT_SIGN: result = imm_sext;
            EXT_LUI:  result = {imm, {(DATA_W-IMM_W){1'b0}}};
            EXT_BR:   result = imm_sext << 2;
            EXT_LB:   result = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
            EXT_LBU:  result = {{(DATA_W-8){1'b0}}, byte_lane};
            EXT_LH, EXT_LHU: begin
                if (off[0]) begin
                    misalign = 1'b1;
                end else if (op == EXT_LH) begin
                    result = {{(DATA_W-16){half_lane[15]}}, half_lane};
                end else begin
                    result = {{(DATA_W-16){1'b0}}, half_lane};
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ext_stage.sv
// ext_stage -- registered extension stage with a 2-entry skid buffer.
//   clk, reset          clock and synchronous active-high reset
//   flush               drop both buffered entries (err_cnt is kept)
//   in_valid/in_ready   input handshake; in_ready is a pure register
//   in_op/in_data/in_off  ExtOp code, immediate or load word, byte offset
//   out_valid/out_ready output handshake
//   out_data/out_misalign extended result and misaligned-halfword flag
//   err_cnt             saturating count of misaligned results delivered
module ext_stage
    import ext_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_off,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_misalign,
    output logic [7:0]        err_cnt
);

    logic [DATA_W-1:0] core_data;
    logic              core_mis;

    logic              main_valid_reg, main_valid_next;
    logic [DATA_W-1:0] main_data_reg,  main_data_next;
    logic              main_mis_reg,   main_mis_next;
    logic              skid_valid_reg, skid_valid_next;
    logic [DATA_W-1:0] skid_data_reg,  skid_data_next;
    logic              skid_mis_reg,   skid_mis_next;
    logic              in_ready_reg,   in_ready_next;
    logic [7:0]        err_cnt_reg,    err_cnt_next;

    logic in_fire;
    logic out_fire;

    ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .OFF_W  (OFF_W)
    ) u_core (
        .op       (in_op),
        .data     (in_data),
        .off      (in_off),
        .result   (core_data),
        .misalign (core_mis)
    );

    assign in_fire  = in_valid && in_ready_reg;
    assign out_fire = main_valid_reg && out_ready;

    always_comb begin
        main_valid_next = main_valid_reg;
        main_data_next  = main_data_reg;
        main_mis_next   = main_mis_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_mis_next   = skid_mis_reg;
        err_cnt_next    = err_cnt_reg;

        if (out_fire && main_mis_reg && (err_cnt_reg != 8'hFF)) begin
            err_cnt_next = err_cnt_reg + 8'd1;
        end

        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (!main_valid_reg || out_fire) begin
            // Main slot frees up: the older skid entry has precedence so
            // ordering stays FIFO. in_ready is low whenever skid is full,
            // so an input beat cannot arrive in the same cycle.
            if (skid_valid_reg) begin
                main_valid_next = 1'b1;
                main_data_next  = skid_data_reg;
                main_mis_next   = skid_mis_reg;
                skid_valid_next = 1'b0;
            end else if (in_fire) begin
                main_valid_next = 1'b1;
                main_data_next  = core_data;
                main_mis_next   = core_mis;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (in_fire) begin
            // Main is held by a stalled consumer: park the beat in skid.
            skid_valid_next = 1'b1;
            skid_data_next  = core_data;
            skid_mis_next   = core_mis;
        end

        in_ready_next = !skid_valid_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            main_mis_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_mis_reg   <= 1'b0;
            in_ready_reg   <= 1'b0;
            err_cnt_reg    <= 8'd0;
        end else begin
            main_valid_reg <= main_valid_next;
            main_data_reg  <= main_data_next;
            main_mis_reg   <= main_mis_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_mis_reg   <= skid_mis_next;
            in_ready_reg   <= in_ready_next;
            err_cnt_reg    <= err_cnt_next;
        end
    end

    assign in_ready     = in_ready_reg;
    assign out_valid    = main_valid_reg;
    assign out_data     = main_data_reg;
    assign out_misalign = main_mis_reg;
    assign err_cnt      = err_cnt_reg;

endmodule

// File: tb/tb_ext_stage.sv
// tb_ext_stage -- scoreboard bench for ext_stage (DATA_W=32, IMM_W=16).
// The driver pushes the expected result of every accepted beat into a
// queue; a negedge monitor pops and compares on each output transfer.
module tb_ext_stage;
    import ext_stage_pkg::*;

    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;
    localparam int OFF_W  = 2;

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]        in_op;
    logic [DATA_W-1:0] in_data, out_data;
    logic [OFF_W-1:0]  in_off;
    logic              out_misalign;
    logic [7:0]        err_cnt;

    typedef struct {
        logic [31:0] d;
        logic        m;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   err_model = 0;

    ext_stage #(.DATA_W(DATA_W), .IMM_W(IMM_W), .OFF_W(OFF_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_data      (in_data),
        .in_off       (in_off),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_misalign (out_misalign),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic on the mode rules.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] data,
                                          input logic [1:0] off, output logic mis);
        longint imm  = longint'(data) % 65536;
        longint simm = (imm >= 32768) ? imm - 65536 : imm;
        int     o    = int'(off);
        longint b    = (longint'(data) / (longint'(1) << (8 * o))) % 256;
        longint h    = (longint'(data) / (longint'(1) << (16 * (o / 2)))) % 65536;
        longint r    = 0;
        mis = 1'b0;
        case (op)
            3'd0: r = imm;
            3'd1: r = simm;
            3'd2: r = imm * 65536;
            3'd3: r = simm * 4;
            3'd4: r = (b >= 128) ? b - 256 : b;
            3'd5: r = b;
            default: begin
                if (o % 2 == 1) begin
                    mis = 1'b1;
                    r   = 0;
                end else if (op == 3'd6) begin
                    r = (h >= 32768) ? h - 65536 : h;
                end else begin
                    r = h;
                end
            end
        endcase
        return r[31:0];
    endfunction

    // One clock: drive at posedge+1, decide acceptance from the registered
    // in_ready, return at the next posedge+1.
    task automatic cycle(input logic v, input logic [2:0] op, input logic [31:0] d,
                         input logic [1:0] off, input logic ordy, input logic fl,
                         output bit acc);
        bit rs;
        in_valid  = v;
        in_op     = op;
        in_data   = d;
        in_off    = off;
        out_ready = ordy;
        flush     = fl;
        rs        = reset;
        acc       = v && in_ready && !fl && !rs;
        @(posedge clk);
        #1;
        if (fl || rs) sb.delete();
        if (rs) err_model = 0;
    endtask

    task automatic send(input logic v, input logic [2:0] op, input logic [31:0] d,
                        input logic [1:0] off, input logic ordy, input logic fl,
                        input bit use_model, input logic [31:0] ed, input logic em,
                        input bit lat, output bit acc);
        exp_t e;
        logic m;
        cycle(v, op, d, off, ordy, fl, acc);
        if (acc) begin
            if (use_model) begin
                e.d = model(op, d, off, m);
                e.m = m;
            end else begin
                e.d = ed;
                e.m = em;
            end
            e.cyc = lat ? cyc : -1;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 64 && (sb.size() != 0 || out_valid); i++)
            cycle(1'b0, 3'd0, 32'd0, 2'd0, 1'b1, 1'b0, acc);
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: compare each output transfer, track hold stability and err_cnt.
    initial begin
        bit          stall_prev = 1'b0;
        logic [31:0] held_d = '0;
        logic        held_m = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && out_valid) begin
                    chk("hold_data", out_data, held_d);
                    chk("hold_mis", 32'(out_misalign), 32'(held_m));
                end
                if (out_valid && out_ready) begin
                    chk("err_cnt", 32'(err_cnt), 32'(err_model));
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got %h want none", out_data);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("out_mis", 32'(out_misalign), 32'(e.m));
                        if (e.cyc >= 0) chk("latency", 32'(cyc), 32'(e.cyc));
                        if (e.m && err_model < 255) err_model++;
                    end
                end
                stall_prev = out_valid && !out_ready && !flush;
                held_d     = out_data;
                held_m     = out_misalign;
            end
        end
    end

    initial begin
        bit          acc;
        logic [31:0] lb_exp[4];
        logic [2:0]  imm_ops[4];
        logic [31:0] imm_exp[4];
        int          tries;

        lb_exp  = '{32'h0000007F, 32'hFFFFFFF2, 32'hFFFFFF81, 32'hFFFFFF80};
        imm_ops = '{EXT_ZERO, EXT_SIGN, EXT_LUI, EXT_BR};
        imm_exp = '{32'h00008888, 32'hFFFF8888, 32'h88880000, 32'hFFFE2220};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 3'd0;
        in_data = '0; in_off = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_mis", 32'(out_misalign), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Immediate modes back to back, latency checked.
        for (int i = 0; i < 4; i++) begin
            send(1'b1, imm_ops[i], 32'h00008888, 2'd0, 1'b1, 1'b0, 1'b0, imm_exp[i], 1'b0, 1'b1, acc);
            chk("imm_accept", 32'(acc), 32'd1);
        end
        drain();

        // Byte lanes and an aligned unsigned halfword.
        for (int i = 0; i < 4; i++)
            send(1'b1, EXT_LB, 32'h8081F27F, 2'(i), 1'b1, 1'b0, 1'b0, lb_exp[i], 1'b0, 1'b1, acc);
        send(1'b1, EXT_LHU, 32'h8081F27F, 2'd2, 1'b1, 1'b0, 1'b0, 32'h00008081, 1'b0, 1'b1, acc);
        drain();

        // Misaligned halfword, then saturation of err_cnt.
        send(1'b1, EXT_LH, 32'h8081F27F, 2'd1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, acc);
        drain();
        chk("err_after_one", 32'(err_cnt), 32'd1);
        for (int i = 0; i < 300; i++)
            send(1'b1, EXT_LH, $urandom, 2'd1, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, acc);
        drain();
        chk("err_saturated", 32'(err_cnt), 32'd255);

        // Consumer stalled: two beats fit, third waits.
        send(1'b1, EXT_SIGN, 32'h0000_1234, 2'd0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, acc);
        send(1'b1, EXT_LBU, 32'hA1B2C3D4, 2'd3, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, acc);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        send(1'b1, EXT_LH, 32'h9ABC_DEF0, 2'd2, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, acc);
        chk("third_rejected", 32'(acc), 32'd0);
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 10) begin
            send(1'b1, EXT_LH, 32'h9ABC_DEF0, 2'd2, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, acc);
            tries++;
        end
        chk("third_accepted", 32'(acc), 32'd1);
        drain();

        // Flush with both entries full and a beat offered.
        send(1'b1, EXT_ZERO, 32'h1111_1111, 2'd0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, acc);
        send(1'b1, EXT_ZERO, 32'h2222_2222, 2'd0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, acc);
        send(1'b1, EXT_ZERO, 32'h3333_3333, 2'd0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0, acc);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_err_kept", 32'(err_cnt), 32'd255);
        drain();

        // Reset mid-stream with skid full.
        send(1'b1, EXT_LUI, 32'h0000_ABCD, 2'd0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, acc);
        send(1'b1, EXT_BR, 32'h0000_7FFF, 2'd0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, acc);
        reset = 1'b1;
        send(1'b1, EXT_LB, 32'h1234_5678, 2'd1, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, acc);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", out_data, 32'd0);
        chk("mid_rst_out_mis", 32'(out_misalign), 32'd0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        reset = 1'b0;
        cycle(1'b0, 3'd0, 32'd0, 2'd0, 1'b0, 1'b0, acc);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);

        // Randomized traffic with back-pressure and occasional flush.
        for (int i = 0; i < 3000; i++) begin
            send(($urandom % 4) != 0, 3'($urandom), $urandom, 2'($urandom),
                 ($urandom % 4) != 0, ($urandom % 64) == 0,
                 1'b1, 32'd0, 1'b0, 1'b0, acc);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
